// File: rtl/ysyx_22050078_pcu.sv
// Program-counter unit: holds the fetch PC, hands it to the IFU over valid/ready,
// and applies trap/jump redirects (including ones that arrive during a stall) plus halt.
module ysyx_22050078_pcu #(
  parameter int unsigned          CPU_WIDTH  = 64,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = CPU_WIDTH'(64'h8000_0000),
  parameter int unsigned          INST_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ready,
  input  logic                 i_stall,
  input  logic                 i_jump_en,
  input  logic [CPU_WIDTH-1:0] i_jump_pc,
  input  logic                 i_trap_en,
  input  logic [CPU_WIDTH-1:0] i_trap_pc,
  input  logic                 i_halt,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic                 o_pc_valid,
  output logic                 o_misalign,
  output logic [63:0]          o_fetch_cnt,
  output logic                 o_halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t               state, state_nxt;
  logic [CPU_WIDTH-1:0] pc_nxt;
  logic                 pc_valid_nxt;
  logic                 misalign_nxt;
  logic [63:0]          fetch_cnt_nxt;
  logic                 halted_nxt;

  // Redirect captured while stalled; kind decides whether a later jump may overwrite it.
  logic                 pend_vld, pend_vld_nxt;
  logic                 pend_trap, pend_trap_nxt;
  logic [CPU_WIDTH-1:0] pend_pc, pend_pc_nxt;

  logic                 fire;
  logic                 redir;
  logic [CPU_WIDTH-1:0] redir_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      o_pc        <= RESET_PC;
      o_pc_valid  <= 1'b0;
      o_misalign  <= 1'b0;
      o_fetch_cnt <= 64'd0;
      o_halted    <= 1'b0;
      pend_vld    <= 1'b0;
      pend_trap   <= 1'b0;
      pend_pc     <= '0;
    end else begin
      state       <= state_nxt;
      o_pc        <= pc_nxt;
      o_pc_valid  <= pc_valid_nxt;
      o_misalign  <= misalign_nxt;
      o_fetch_cnt <= fetch_cnt_nxt;
      o_halted    <= halted_nxt;
      pend_vld    <= pend_vld_nxt;
      pend_trap   <= pend_trap_nxt;
      pend_pc     <= pend_pc_nxt;
    end
  end

  // Next-state, next-PC and redirect bookkeeping.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = o_pc;
    pc_valid_nxt  = o_pc_valid;
    misalign_nxt  = 1'b0;
    fetch_cnt_nxt = o_fetch_cnt;
    halted_nxt    = o_halted;
    pend_vld_nxt  = pend_vld;
    pend_trap_nxt = pend_trap;
    pend_pc_nxt   = pend_pc;
    fire          = 1'b0;
    redir         = 1'b0;
    redir_pc      = '0;

    case (state)
      BOOT: begin
        state_nxt    = RUN;
        pc_valid_nxt = 1'b1;
      end
      RUN: begin
        if (i_halt) begin
          state_nxt     = HALT;
          pc_valid_nxt  = 1'b0;
          halted_nxt    = 1'b1;
          pend_vld_nxt  = 1'b0;
          pend_trap_nxt = 1'b0;
        end else if (i_stall) begin
          if (i_trap_en) begin
            pend_vld_nxt  = 1'b1;
            pend_trap_nxt = 1'b1;
            pend_pc_nxt   = i_trap_pc;
          end else if (i_jump_en && !(pend_vld && pend_trap)) begin
            pend_vld_nxt  = 1'b1;
            pend_trap_nxt = 1'b0;
            pend_pc_nxt   = i_jump_pc;
          end
        end else begin
          fire = o_pc_valid & i_ready;
          if (i_trap_en) begin
            redir    = 1'b1;
            redir_pc = i_trap_pc;
          end else if (i_jump_en) begin
            redir    = 1'b1;
            redir_pc = i_jump_pc;
          end else if (pend_vld) begin
            redir    = 1'b1;
            redir_pc = pend_pc;
          end
          if (redir) begin
            pc_nxt       = {redir_pc[CPU_WIDTH-1:2], 2'b00};
            misalign_nxt = |redir_pc[1:0];
          end else if (fire) begin
            pc_nxt = o_pc + CPU_WIDTH'(INST_BYTES);
          end
          if (fire) fetch_cnt_nxt = o_fetch_cnt + 64'd1;
          pend_vld_nxt  = 1'b0;
          pend_trap_nxt = 1'b0;
        end
      end
      HALT: begin
        pc_valid_nxt = 1'b0;
        halted_nxt   = 1'b1;
      end
      default: state_nxt = BOOT;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050078_pcu.sv
// Directed bench for ysyx_22050078_pcu: linear step sequence with hand-computed expectations.
module tb_ysyx_22050078_pcu;

  logic        clk;
  logic        rst;
  logic        i_ready;
  logic        i_stall;
  logic        i_jump_en;
  logic [63:0] i_jump_pc;
  logic        i_trap_en;
  logic [63:0] i_trap_pc;
  logic        i_halt;
  logic [63:0] o_pc;
  logic        o_pc_valid;
  logic        o_misalign;
  logic [63:0] o_fetch_cnt;
  logic        o_halted;

  int vectors;
  int miscompares;

  ysyx_22050078_pcu dut (
    .clk        (clk),
    .rst        (rst),
    .i_ready    (i_ready),
    .i_stall    (i_stall),
    .i_jump_en  (i_jump_en),
    .i_jump_pc  (i_jump_pc),
    .i_trap_en  (i_trap_en),
    .i_trap_pc  (i_trap_pc),
    .i_halt     (i_halt),
    .o_pc       (o_pc),
    .o_pc_valid (o_pc_valid),
    .o_misalign (o_misalign),
    .o_fetch_cnt(o_fetch_cnt),
    .o_halted   (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [63:0] pc, input logic valid,
                         input logic mis, input logic [63:0] cnt, input logic hlt);
    chk({tag, ".pc"},       o_pc,               pc);
    chk({tag, ".valid"},    64'(o_pc_valid),    64'(valid));
    chk({tag, ".misalign"}, 64'(o_misalign),    64'(mis));
    chk({tag, ".cnt"},      o_fetch_cnt,        cnt);
    chk({tag, ".halted"},   64'(o_halted),      64'(hlt));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    i_ready   = 1'b1;
    i_stall   = 1'b0;
    i_jump_en = 1'b0;
    i_jump_pc = 64'd0;
    i_trap_en = 1'b0;
    i_trap_pc = 64'd0;
    i_halt    = 1'b0;

    repeat (2) step();
    chk_all("reset", 64'h8000_0000, 1'b0, 1'b0, 64'd0, 1'b0);

    // release: one BOOT cycle, then sequential fetches
    rst = 1'b0;
    #2;
    chk_all("boot", 64'h8000_0000, 1'b0, 1'b0, 64'd0, 1'b0);
    step(); chk_all("run0", 64'h8000_0000, 1'b1, 1'b0, 64'd0, 1'b0);
    step(); chk_all("run1", 64'h8000_0004, 1'b1, 1'b0, 64'd1, 1'b0);
    step(); chk_all("run2", 64'h8000_0008, 1'b1, 1'b0, 64'd2, 1'b0);
    step(); chk_all("run3", 64'h8000_000C, 1'b1, 1'b0, 64'd3, 1'b0);
    step(); chk_all("run4", 64'h8000_0010, 1'b1, 1'b0, 64'd4, 1'b0);

    // IFU not ready for three cycles
    i_ready = 1'b0;
    step(); chk_all("nrdy0", 64'h8000_0010, 1'b1, 1'b0, 64'd4, 1'b0);
    step(); chk_all("nrdy1", 64'h8000_0010, 1'b1, 1'b0, 64'd4, 1'b0);
    step(); chk_all("nrdy2", 64'h8000_0010, 1'b1, 1'b0, 64'd4, 1'b0);
    i_ready = 1'b1;
    step(); chk_all("rdy", 64'h8000_0014, 1'b1, 1'b0, 64'd5, 1'b0);

    // trap beats jump in the same cycle
    i_jump_en = 1'b1; i_jump_pc = 64'h8000_0100;
    i_trap_en = 1'b1; i_trap_pc = 64'h8000_0200;
    step(); chk_all("prio", 64'h8000_0200, 1'b1, 1'b0, 64'd6, 1'b0);
    i_jump_en = 1'b0; i_trap_en = 1'b0;

    // stalled: jump, trap, jump; trap must survive the later jump
    i_stall = 1'b1;
    i_jump_en = 1'b1; i_jump_pc = 64'h8000_0300;
    step(); chk_all("stl0", 64'h8000_0200, 1'b1, 1'b0, 64'd6, 1'b0);
    i_jump_en = 1'b0; i_trap_en = 1'b1; i_trap_pc = 64'h8000_0400;
    step(); chk_all("stl1", 64'h8000_0200, 1'b1, 1'b0, 64'd6, 1'b0);
    i_trap_en = 1'b0; i_jump_en = 1'b1; i_jump_pc = 64'h8000_0500;
    step(); chk_all("stl2", 64'h8000_0200, 1'b1, 1'b0, 64'd6, 1'b0);
    i_jump_en = 1'b0; i_stall = 1'b0;
    step(); chk_all("unstl", 64'h8000_0400, 1'b1, 1'b0, 64'd7, 1'b0);
    step(); chk_all("pendclr", 64'h8000_0404, 1'b1, 1'b0, 64'd8, 1'b0);

    // misaligned jump target
    i_jump_en = 1'b1; i_jump_pc = 64'h8000_0102;
    step(); chk_all("mis", 64'h8000_0100, 1'b1, 1'b1, 64'd9, 1'b0);
    i_jump_en = 1'b0;
    step(); chk_all("mispulse", 64'h8000_0104, 1'b1, 1'b0, 64'd10, 1'b0);

    // wrap at top of address space
    i_jump_en = 1'b1; i_jump_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); chk_all("top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 64'd11, 1'b0);
    i_jump_en = 1'b0;
    step(); chk_all("wrap", 64'h0, 1'b1, 1'b0, 64'd12, 1'b0);

    // redirect lands even when IFU not ready; no fetch counted
    i_ready = 1'b0; i_jump_en = 1'b1; i_jump_pc = 64'h8000_0020;
    step(); chk_all("jmpnrdy", 64'h8000_0020, 1'b1, 1'b0, 64'd12, 1'b0);
    i_jump_en = 1'b0;

    // halt, then ignore further activity
    i_halt = 1'b1;
    step(); chk_all("halt", 64'h8000_0020, 1'b0, 1'b0, 64'd12, 1'b1);
    i_halt = 1'b0; i_ready = 1'b1;
    i_jump_en = 1'b1; i_jump_pc = 64'h8000_0900;
    step(); chk_all("halt1", 64'h8000_0020, 1'b0, 1'b0, 64'd12, 1'b1);
    step(); chk_all("halt2", 64'h8000_0020, 1'b0, 1'b0, 64'd12, 1'b1);
    i_jump_en = 1'b0;

    // async reset mid-cycle, no clock edge needed
    #2;
    rst = 1'b1;
    #1;
    chk_all("arst", 64'h8000_0000, 1'b0, 1'b0, 64'd0, 1'b0);
    rst = 1'b0;
    step(); chk_all("reboot", 64'h8000_0000, 1'b1, 1'b0, 64'd0, 1'b0);
    step(); chk_all("rerun", 64'h8000_0004, 1'b1, 1'b0, 64'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_22050078_pcu.md
# ysyx_22050078_pcu

Program-counter unit sitting directly upstream of the fetch stage. It holds the architectural fetch PC, presents it to the IFU with a valid/ready handshake, advances it sequentially, and applies jump/trap redirects with fixed priority. It also handles pipeline stalls, halt on ebreak, and counts accepted fetches for the simulation environment.

## Interface
- `CPU_WIDTH`, 64: PC and data width.
- `RESET_PC`, 64'h8000_0000: first PC fetched after reset.
- `INST_BYTES`, 4: sequential PC increment.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_ready` in 1: IFU accepts `o_pc` this cycle.
- `i_stall` in 1: downstream hazard; freezes PC advance.
- `i_jump_en` in 1: branch/jump taken (from EXU).
- `i_jump_pc` in CPU_WIDTH: jump target.
- `i_trap_en` in 1: trap/mret redirect (from CSR unit).
- `i_trap_pc` in CPU_WIDTH: trap target (mtvec/mepc).
- `i_halt` in 1: ebreak retired; stop fetching.
- `o_pc` out CPU_WIDTH: current fetch PC (registered).
- `o_pc_valid` out 1: `o_pc` is valid for fetch.
- `o_misalign` out 1: one-cycle pulse, a redirect target had bits[1:0] != 0.
- `o_fetch_cnt` out 64: number of accepted fetches.
- `o_halted` out 1: unit is in HALT.

## Operation
- FSM states: BOOT, RUN, HALT.
- Reset (async, while `rst`=1): state BOOT, `o_pc`=RESET_PC, `o_pc_valid`=0, `o_misalign`=0, `o_fetch_cnt`=0, `o_halted`=0, pending redirect cleared.
- BOOT: exactly one cycle after reset release with `o_pc_valid`=0; then RUN.
- RUN: `o_pc_valid`=1. fire = `o_pc_valid` & `i_ready` & !`i_stall`.
- Next-PC priority (evaluated each RUN cycle, not stalled): trap input > jump input > pending redirect > (fire ? `o_pc`+INST_BYTES : `o_pc`).
- A live redirect when not stalled loads `o_pc` next cycle regardless of `i_ready`; the un-accepted wrong-path PC is discarded.
- `i_stall`=1: `o_pc` held, no fire; any redirect is latched into a pending register (target + kind). A later trap overwrites any pending entry; a later jump overwrites only a pending jump, never a pending trap.
- First non-stalled cycle after stall: pending target (or a live higher-priority redirect) is loaded; pending cleared.
- Target alignment: bits[1:0] of any loaded redirect target are forced to 0; if either was 1, `o_misalign` pulses high the cycle the target appears on `o_pc`.
- Addition is modulo 2^CPU_WIDTH; `o_pc`=all-ones-minus-3 plus 4 wraps to 0, no flag.
- `o_fetch_cnt` increments by 1 on each fire; wraps silently at 2^64.
- `i_halt`=1 in RUN: next state HALT (takes priority over redirects, pending discarded). HALT: `o_pc_valid`=0, `o_halted`=1, `o_pc` and counter frozen; exit only by reset.
- `rst` asserted mid-operation: immediate return to reset values, pending redirect lost.

## Timing
- `o_pc` and all outputs registered; no combinational input-to-output path.
- Sequential advance: fire at cycle N -> `o_pc`+4 visible at N+1.
- Redirect latency: `i_jump_en`/`i_trap_en` at cycle N (not stalled) -> target on `o_pc` at N+1.
- Stalled redirect: latched at N; applied one cycle after `i_stall` falls.
- First valid fetch: second rising edge after `rst` release.
- `o_halted` high the cycle after `i_halt` sampled.

## Test plan
- Reset release, `i_ready`=1 constant -> `o_pc_valid` 0 for one cycle, then `o_pc` = 8000_0000, 8000_0004, 8000_0008; `o_fetch_cnt` = 3 after three fires.
- `i_ready`=0 for 3 cycles at PC 8000_0010 -> `o_pc` holds 8000_0010, counter unchanged; resumes 8000_0014 after ready returns.
- Same-cycle `i_jump_en` (8000_0100) and `i_trap_en` (8000_0200) -> next `o_pc` = 8000_0200.
- `i_stall`=1, jump to 8000_0300 then trap to 8000_0400 then jump to 8000_0500 during stall -> after stall drops, `o_pc` = 8000_0400.
- Jump target 8000_0102 -> `o_pc` = 8000_0100, `o_misalign` high exactly one cycle.
- `i_halt` at PC 8000_0020 -> `o_pc_valid`=0, `o_halted`=1, PC frozen; async `rst` mid-halt -> all outputs to reset values without a clock edge.
